// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int          DIGIT_W        = 4;
    localparam logic [3:0]  ADD3_THRESHOLD = 4'd5;
    localparam logic [3:0]  ADD3_VALUE     = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added before the next shift.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    // Digits never exceed 9, so the corrected value (at most 12) always fits in 4 bits.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADD3_THRESHOLD) begin
            digit_o = digit_i + ADD3_VALUE;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one operand bit per clock (shift-and-add-3).
// Optional macro BIN2BCD_AUTOSTART_EN also starts a conversion whenever SW changes while idle.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        SW,
    input  logic                    start,
    output logic [4*DIGITS-1:0]     BCD,
    output logic [7:0]              LD,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SCR_W = DIGIT_W * DIGITS;

    state_t              state_q;
    logic [WIDTH-1:0]    operand_q;
    logic [SCR_W-1:0]    scratch_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [SCR_W-1:0]    bcd_q;
    logic [7:0]          ld_q;
    logic                busy_q;
    logic                done_q;

    logic [SCR_W-1:0]    adjusted;
    logic [SCR_W-1:0]    scratch_d;
    logic [WIDTH-1:0]    operand_d;
    logic                launch;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .digit_o (adjusted[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Correct digits first, then shift the next operand MSB into the scratch units digit.
    assign {scratch_d, operand_d} = {adjusted, operand_q} << 1;

`ifdef BIN2BCD_AUTOSTART_EN
    logic [WIDTH-1:0]    lastSw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lastSw_q <= '0;
        end else if (state_q == IDLE && launch) begin
            lastSw_q <= SW;
        end
    end

    assign launch = start || (SW != lastSw_q);
`else
    assign launch = start;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            operand_q <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ld_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        operand_q <= SW;
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(WIDTH);
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    operand_q <= operand_d;
                    scratch_q <= scratch_d;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    bcd_q   <= scratch_q;
                    ld_q    <= scratch_q[7:0];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BCD  = bcd_q;
    assign LD   = ld_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq (WIDTH=8, DIGITS=3); autostart scenario built with BIN2BCD_AUTOSTART_EN.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  SW;
    logic        start;
    logic [11:0] BCD;
    logic [7:0]  LD;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .SW    (SW),
        .start (start),
        .BCD   (BCD),
        .LD    (LD),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Pulse start for one edge with the given operand, then wait for done.
    // latency counts edges after the start edge (-1 on timeout); busyCount counts sampled busy cycles.
    task automatic doConvert(input logic [7:0] sw, output int latency, output int busyCount);
        @(negedge clk);
        SW    = sw;
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        busyCount = int'(busy);
        latency   = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            busyCount += int'(busy);
            if (done) begin
                latency = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        SW    = 8'd0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (BCD !== 12'h000 || LD !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: BCD=%h LD=%h busy=%b done=%b, required 000 00 0 0", BCD, LD, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        int lat, bc;
        doConvert(8'd0, lat, bc);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("[TB] FAIL zero_latency: got %0d, required 9", lat);
        end
        checks++;
        if (BCD !== 12'h000 || LD !== 8'h00) begin
            errors++;
            $display("[TB] FAIL zero_value: BCD=%h LD=%h, required 000 00", BCD, LD);
        end
    endtask

    task automatic test_sweep();
        logic [7:0]  swVec  [7] = '{8'd5, 8'd16, 8'd35, 8'd53, 8'd100, 8'd136, 8'd146};
        logic [11:0] bcdVec [7] = '{12'h005, 12'h016, 12'h035, 12'h053, 12'h100, 12'h136, 12'h146};
        int lat, bc;
        for (int i = 0; i < 7; i++) begin
            doConvert(swVec[i], lat, bc);
            checks++;
            if (lat !== 9 || BCD !== bcdVec[i] || LD !== bcdVec[i][7:0]) begin
                errors++;
                $display("[TB] FAIL sweep_%0d: lat=%0d BCD=%h LD=%h, required lat=9 BCD=%h LD=%h",
                         swVec[i], lat, BCD, LD, bcdVec[i], bcdVec[i][7:0]);
            end
        end
    endtask

    task automatic test_max_busy();
        int lat, bc;
        doConvert(8'd255, lat, bc);
        checks++;
        if (BCD !== 12'h255 || LD !== 8'h55) begin
            errors++;
            $display("[TB] FAIL max_value: BCD=%h LD=%h, required 255 55", BCD, LD);
        end
        checks++;
        if (bc !== 9) begin
            errors++;
            $display("[TB] FAIL max_busy_cycles: got %0d, required 9", bc);
        end
        // Result must hold while idle.
        repeat (5) @(negedge clk);
        checks++;
        if (BCD !== 12'h255 || LD !== 8'h55 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_value: BCD=%h LD=%h busy=%b, required 255 55 0", BCD, LD, busy);
        end
    endtask

    // Second start and an SW change mid-conversion must both be ignored.
    task automatic test_ignore_start();
        int doneCount = 0;
        @(negedge clk);
        SW    = 8'd99;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        SW    = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        SW = 8'd99;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checks++;
        if (BCD !== 12'h099) begin
            errors++;
            $display("[TB] FAIL ignore_value: BCD=%h, required 099", BCD);
        end
        checks++;
        if (doneCount !== 1) begin
            errors++;
            $display("[TB] FAIL ignore_done_count: got %0d, required 1", doneCount);
        end
    endtask

    task automatic test_reset_mid();
        int doneCount = 0;
        int lat, bc;
        @(negedge clk);
        SW    = 8'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        SW  = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || BCD !== 12'h000 || LD !== 8'h00 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_state: busy=%b BCD=%h LD=%h done=%b, required 0 000 00 0", busy, BCD, LD, done);
        end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checks++;
        if (doneCount !== 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_no_done: got %0d, required 0", doneCount);
        end
        doConvert(8'd200, lat, bc);
        checks++;
        if (lat !== 9 || BCD !== 12'h200 || LD !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_mid_restart: lat=%0d BCD=%h LD=%h, required 9 200 00", lat, BCD, LD);
        end
    endtask

    // start held high: one conversion every WIDTH+2 = 10 cycles.
    task automatic test_back_to_back();
        int firstDone = -1;
        int secondDone = -1;
        @(negedge clk);
        SW    = 8'd37;
        start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                if (firstDone < 0) begin
                    firstDone = k;
                end else begin
                    secondDone = k;
                    break;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (firstDone < 0 || secondDone < 0 || (secondDone - firstDone) !== 10) begin
            errors++;
            $display("[TB] FAIL back_to_back_period: first=%0d second=%0d, required spacing 10", firstDone, secondDone);
        end
        checks++;
        if (BCD !== 12'h037 || LD !== 8'h37) begin
            errors++;
            $display("[TB] FAIL back_to_back_value: BCD=%h LD=%h, required 037 37", BCD, LD);
        end
        repeat (15) @(negedge clk);
    endtask

`ifdef BIN2BCD_AUTOSTART_EN
    task automatic test_autostart();
        int lat = -1;
        int extra = 0;
        @(negedge clk);
        rst = 1'b1;
        SW  = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        SW = 8'd42;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat < 0 || LD !== 8'h42) begin
            errors++;
            $display("[TB] FAIL autostart_value: lat=%0d LD=%h, required done within 10 and LD=42", lat, LD);
        end
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("[TB] FAIL autostart_hold: got %0d extra done pulses, required 0", extra);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_sweep();
        test_max_busy();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef BIN2BCD_AUTOSTART_EN
        test_autostart();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 8: binary input width; supported range 4..10.
REQ-002 Parameter DIGITS, default 3: number of BCD digits, equal to ceil(WIDTH*log10(2)); 3 for WIDTH=8.
REQ-003 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 SW  input  WIDTH  unsigned binary operand from the switches.
REQ-006 start  input  1  request a conversion of SW; sampled on each rising edge.
REQ-007 BCD  output  4*DIGITS  last completed result, digit 0 (units) in bits [3:0]; registered.
REQ-008 LD  output  8  tens and units digits of BCD (BCD[7:0]) for the LEDs; registered.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse marking that BCD and LD have just been updated.

Function
REQ-011 The FSM SHALL have the states IDLE, SHIFT and FINISH; the reset state SHALL be IDLE.
REQ-012 In IDLE, start=1 at an edge SHALL latch SW into the shift register, clear the BCD scratch register, load the iteration counter with WIDTH, and move to SHIFT.
REQ-013 In SHIFT, each edge SHALL add 3 to every scratch digit >= 5, then left-shift {scratch, operand} by one bit, and decrement the counter.
REQ-014 When the counter reaches 0, the FSM SHALL move to FINISH after exactly WIDTH SHIFT edges.
REQ-015 In FINISH, the edge SHALL copy the scratch register to BCD and LD, pulse done for one cycle, and return to IDLE.
REQ-016 Latency: if start is sampled at edge N, BCD/LD SHALL be valid and done=1 from edge N+WIDTH+1, which is edge N+9 for WIDTH=8.
REQ-017 busy SHALL be 1 in SHIFT and FINISH and 0 in IDLE.
REQ-018 start SHALL be ignored while busy=1; no queuing.
REQ-019 SW changes after the latching edge SHALL NOT affect the conversion in progress.
REQ-020 start held high continuously SHALL cause back-to-back conversions, one every WIDTH+2 cycles.
REQ-021 BCD and LD SHALL hold their last value between conversions.
REQ-022 No per-digit add-3 result SHALL exceed 4 bits; each digit SHALL remain within 0..9 after every step.

Reset
REQ-023 rst=1 SHALL force IDLE, BCD=0, LD=0, busy=0, done=0, and clear the counter and scratch registers, including in the middle of a conversion.
REQ-024 rst SHALL take priority over start at the same edge.

Configuration
REQ-025 Macro BIN2BCD_AUTOSTART_EN defined: in IDLE, the block SHALL also begin a conversion when SW differs from the value latched by the previous conversion (reset value 0), so LD tracks SW without a start pulse.
REQ-026 BIN2BCD_AUTOSTART_EN undefined: conversions SHALL start only on start, and no last-SW register SHALL be built.

Structure
REQ-027 A shared package bin2bcd_pkg SHALL hold the FSM state enumeration, the add-3 threshold constant (5) and the digit width constant (4).
REQ-028 The per-digit "add 3 if >= 5" logic SHALL be one combinational sub-module, bcd_digit_adj, instantiated DIGITS times.

Verification
REQ-029 Reset, then start pulse with SW=0 -> done at edge +9, BCD=0x000, LD=0x00.
REQ-030 Sweep SW = 5, 16, 35, 53, 100, 136, 146, each with one start pulse -> BCD = 0x005, 0x016, 0x035, 0x053, 0x100, 0x136, 0x146; LD = low byte of each.
REQ-031 SW=255 with start -> BCD=0x255, LD=0x55, busy high for exactly 9 cycles.
REQ-032 A second start pulse, and an SW change to 7, applied mid-conversion of SW=99 -> result BCD=0x099; one done only.
REQ-033 rst asserted at SHIFT cycle 4 of SW=200 -> IDLE next cycle, BCD=0, no done; a new start with SW=200 -> BCD=0x200.
REQ-034 With BIN2BCD_AUTOSTART_EN: SW changed 0 -> 42, no start -> done within 10 cycles, LD=0x42; SW held -> no further done.
